// File: rtl/sextium_pkg.sv
// Shared definitions for the Sextium III core: word width, syscall codes
// and the I/O unit state encoding.
package sextium_pkg;

    localparam int WORD_W = 16;

    localparam int SYS_HALT  = 0;
    localparam int SYS_READ  = 1;
    localparam int SYS_WRITE = 2;

    typedef enum logic [2:0] {
        IO_IDLE,
        IO_READ,
        IO_WRITE,
        IO_NOP,
        IO_DRAIN,
        IO_HALT
    } io_state_t;

endpackage

// File: rtl/io_unit_if.sv
// Valid/ready input and output word streams of the syscall I/O unit.
// The master side is the I/O unit, the slave side is the stream environment.
interface io_unit_if #(
    parameter int W = sextium_pkg::WORD_W
) ();

    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/io_txfifo.sv
// Synchronous output FIFO for the I/O unit: push/full, pop/empty/head,
// asynchronous active-low reset. DEPTH must be a power of two, at least 2.
module io_txfifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/io_unit.sv
// Syscall I/O unit: executes HALT / READ / WRITE selected by ACC against the
// rx/tx streams. Define IO_TXFIFO_EN to buffer WRITEs in a TXDEPTH-entry FIFO.
module io_unit
    import sextium_pkg::*;
#(
    parameter int W       = WORD_W,
    parameter int TXDEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         runio,
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] dr_in,
    output logic         iobusy,
    output logic [W-1:0] io_out,
    output logic         io_wr,
    output logic         halted,
    io_unit_if.master    io
);

    io_state_t    state_q, state_d;
    logic [W-1:0] dr_q, dr_d;
    logic [W-1:0] io_out_q, io_out_d;
    logic         io_wr_q, io_wr_d;
    logic         write_done;
    logic         tx_drained;

`ifdef IO_TXFIFO_EN
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic [W-1:0] fifo_head;

    // Push decision sees only the occupancy at the start of the cycle.
    assign fifo_push = (state_q == IO_WRITE) && !fifo_full;
    assign fifo_pop  = !fifo_empty && io.tx_ready;

    io_txfifo #(
        .W     (W),
        .DEPTH (TXDEPTH)
    ) u_txfifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (dr_q),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign write_done  = fifo_push;
    assign tx_drained  = fifo_empty;
    assign io.tx_valid = !fifo_empty;
    assign io.tx_data  = fifo_empty ? '0 : fifo_head;
`else
    assign write_done  = io.tx_ready;
    assign tx_drained  = 1'b1;
    assign io.tx_valid = (state_q == IO_WRITE);
    assign io.tx_data  = (state_q == IO_WRITE) ? dr_q : '0;
`endif

    always_comb begin
        state_d  = state_q;
        dr_d     = dr_q;
        io_out_d = io_out_q;
        io_wr_d  = 1'b0;
        unique case (state_q)
            IO_IDLE: begin
                if (runio) begin
                    dr_d = dr_in;
                    if (acc_in == W'(SYS_HALT)) begin
                        state_d = IO_DRAIN;
                    end else if (acc_in == W'(SYS_READ)) begin
                        state_d = IO_READ;
                    end else if (acc_in == W'(SYS_WRITE)) begin
                        state_d = IO_WRITE;
                    end else begin
                        state_d = IO_NOP;
                    end
                end
            end
            IO_READ: begin
                if (io.rx_valid) begin
                    io_out_d = io.rx_data;
                    io_wr_d  = 1'b1;
                    state_d  = IO_IDLE;
                end
            end
            IO_WRITE: begin
                if (write_done) begin
                    state_d = IO_IDLE;
                end
            end
            IO_NOP: begin
                state_d = IO_IDLE;
            end
            IO_DRAIN: begin
                if (tx_drained) begin
                    state_d = IO_HALT;
                end
            end
            IO_HALT: begin
                state_d = IO_HALT;
            end
            default: begin
                state_d = IO_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IO_IDLE;
            dr_q     <= '0;
            io_out_q <= '0;
            io_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dr_q     <= dr_d;
            io_out_q <= io_out_d;
            io_wr_q  <= io_wr_d;
        end
    end

    assign iobusy      = (state_q != IO_IDLE);
    assign halted      = (state_q == IO_HALT);
    assign io.rx_ready = (state_q == IO_READ);
    assign io_out      = io_out_q;
    assign io_wr       = io_wr_q;

endmodule

// File: doc/io_unit.md
# io_unit

Syscall I/O unit for the Sextium III core. It sits directly downstream of the instruction controller and consumes its `runio` request. It executes the syscall selected by ACC (halt, read word, write word) against valid/ready input and output streams, and drives `iobusy`/`io_out` back to the controller and datapath. It also keeps the core halted after a HALT syscall.

## Interface
Parameters:
- `W`, 16, datapath word width (ACC, DR, stream data).
- `TXDEPTH`, 4, output FIFO depth, power of two; used only when `IO_TXFIFO_EN` is defined.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `runio`  in  1  syscall request from the controller; high in the DECODE cycle of SYSCALL, then equal to `iobusy` while the controller waits.
- `acc_in`  in  W  syscall code: 0 = HALT, 1 = READ, 2 = WRITE, anything else = NOP.
- `dr_in`  in  W  WRITE argument.
- `iobusy`  out  1  unit not idle; the controller stalls in IOWAIT while this is high.
- `io_out`  out  W  last word read; feeds the ACC mux IO input.
- `io_wr`  out  1  one-cycle pulse: `io_out` is newly valid, ACC must load it.
- `halted`  out  1  core halted; sticky until reset.
- `rx_data`  in  W  input stream data.
- `rx_valid`  in  1  input word available.
- `rx_ready`  out  1  unit accepts an input word.
- `tx_data`  out  W  output stream data.
- `tx_valid`  out  1  output word available.
- `tx_ready`  in  1  sink accepts the output word.

## Operation
- States: IDLE, READ, WRITE, NOP, DRAIN, HALT.
- `iobusy` = (state != IDLE), decoded directly from the state register.
- Reset values: state IDLE, `iobusy` 0, `io_out` 0, `io_wr` 0, `halted` 0, `rx_ready` 0, `tx_valid` 0, `tx_data` 0, FIFO empty.
- Request acceptance:
  - A request is accepted only when `runio` is high in IDLE.
  - `runio` is ignored in every other state.
  - On acceptance, `acc_in` is decoded once and `dr_in` is captured into an internal register. Later changes on either input have no effect.
- Transitions out of IDLE on an accepted request:
  - code 0 → DRAIN
  - code 1 → READ
  - code 2 → WRITE
  - any other code → NOP
- NOP: lasts exactly one cycle, then IDLE. No stream activity.
- READ:
  - `rx_ready` = 1 while in READ.
  - On the edge where `rx_valid` && `rx_ready`: `io_out` ← `rx_data`, `io_wr` ← 1 for the next cycle only, state → IDLE.
- WRITE (no FIFO):
  - `tx_valid` = 1 and `tx_data` = captured DR while in WRITE.
  - On the edge where `tx_ready` is high: `tx_valid` falls, state → IDLE.
- DRAIN: moves to HALT on the next edge without FIFO; with the FIFO it waits until the FIFO is empty.
- HALT:
  - `halted` = 1 and `iobusy` = 1.
  - Absorbing state; only reset leaves it.
- Stream outputs do not depend combinationally on `rx_valid` or `tx_ready`.
- Reset asserted mid-operation: the operation is abandoned, no partial `io_wr` is issued, and a pending `tx_valid` is dropped.

## Timing
- `runio` high in cycle T (IDLE) → `iobusy` = 1 from T+1.
- NOP: `iobusy` high for exactly one cycle (T+1); low at T+2.
- READ with `rx_valid` already high at T+1: handshake at the end of T+1; `iobusy` = 0 and `io_wr` = 1 in T+2.
- READ minimum busy time is one cycle. Otherwise it is unbounded, waiting on `rx_valid`.
- WRITE without FIFO: `tx_valid` rises at T+1; `iobusy` falls the cycle after `tx_ready` is seen high.
- Back-to-back syscalls: a new request is accepted in the first IDLE cycle after completion.

## Configuration
- Macro `IO_TXFIFO_EN`.
- Defined:
  - WRITE pushes the captured DR into a TXDEPTH-entry FIFO when it is not full, then returns to IDLE. `iobusy` is high for one cycle.
  - If the FIFO is full, WRITE waits until an entry is freed, then pushes on the next edge.
  - A push uses the occupancy at the start of the cycle; a same-cycle pop does not enable a push into a full FIFO.
  - `tx_valid` = FIFO not empty; `tx_data` = FIFO head. Pops occur on `tx_valid` && `tx_ready`, independent of the main state.
  - Pointers wrap modulo TXDEPTH; the count is log2(TXDEPTH)+1 bits wide.
  - DRAIN holds until the FIFO is empty, so `halted` rises only after the last word has left.
- Undefined: unbuffered WRITE as described under Operation; no FIFO storage is instantiated.

## Structure
- Shared package `sextium_pkg`:
  - syscall code constants `SYS_HALT`, `SYS_READ`, `SYS_WRITE`;
  - the `io_state_t` enum;
  - default word width.
- Sub-module `io_txfifo`: synchronous FIFO with push/full, pop/empty/head and the same asynchronous active-low reset. Instantiated only under `IO_TXFIFO_EN`.

## Test plan
- Reset low mid-READ, then release → all outputs at reset values, state IDLE, no `io_wr` pulse.
- ACC=1, `rx_valid` with `rx_data`=0x1234 already present → `iobusy` high for exactly 1 cycle, then `io_out`=0x1234 and a single-cycle `io_wr`.
- ACC=2, DR=0xBEEF, `tx_ready` held low 3 cycles, FIFO off → `tx_valid` high 4 cycles with `tx_data`=0xBEEF; `iobusy` drops the cycle after acceptance; exactly one word emitted.
- FIFO on, 5 WRITEs of 1..5 with `tx_ready`=0 → first four WRITEs take 1 busy cycle each; the fifth stays busy until `tx_ready` goes high, then the output order is 1,2,3,4,5.
- ACC=0 with 2 words queued (FIFO on) → `halted` rises only after both words leave; `iobusy` then stays high and later `runio` pulses are ignored.
- ACC=7 → `iobusy` high for one cycle, no stream activity, `io_out` unchanged.
